irq_ctl: RTL and testbench
==========================

IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: cs  input  1  chip select, high = register access.
REQ-004 SHALL have port: we  input  1  write enable, high = write (qualified by cs).
REQ-005 SHALL have port: rs  input  2  register select.
REQ-006 SHALL have port: din  input  8  CPU write data.
REQ-007 SHALL have port: dout  output  8  registered read data.
REQ-008 SHALL have port: src  input  8  interrupt sources, active-high, asynchronous to clk; bit 0 highest priority.
REQ-009 SHALL have port: irq  output  1  registered interrupt request to CPU, active-high.

Function
REQ-010 SHALL pass each src bit through a 2-flop synchronizer (s1, s2) plus a history flop (s3) for edge detection.
REQ-011 SHALL hold per-source MODE bit: 1 = rising-edge, 0 = level.
REQ-012 Edge mode: PEND[i] SHALL set on the cycle where s2[i]=1 and s3[i]=0, and hold until cleared by REQ-017 or REQ-018.
REQ-013 Level mode: PEND[i] SHALL equal s2[i] each cycle; clear writes have no effect.
REQ-014 Set SHALL win over clear when both occur on PEND[i] in the same cycle.
REQ-015 Register map (rs): 0 PEND, 1 MASK, 2 MODE, 3 VEC.
REQ-016 MASK and MODE SHALL be read/write; written from din when cs=1, we=1 at the clk edge.
REQ-017 Write to PEND (rs=0) SHALL clear every edge-mode PEND bit where din bit = 1 (write-1-to-clear).
REQ-018 Write to VEC (rs=3) SHALL clear edge-mode PEND[din[2:0]] (acknowledge); din[7:3] ignored.
REQ-019 ACT = PEND & MASK; WIN = index of lowest set bit of ACT (fixed priority, bit 0 highest).
REQ-020 VEC read value SHALL be {|ACT, 4'b0000, WIN}; WIN = 0 when ACT = 0.
REQ-021 PEND read SHALL return raw PEND (unmasked).
REQ-022 dout SHALL register, every clk edge regardless of cs/we, the register selected by rs, using pre-edge state; data is valid one cycle after rs is presented.
REQ-023 irq SHALL register |ACT each clk edge.
REQ-024 Latency: src[i] rising, set up before edge E0 with MASK[i]=1, SHALL give PEND[i]=1 after E2 and irq=1 after E3.
REQ-025 Pulses on src shorter than one clk period are not guaranteed to register; pulses of 2+ clk periods SHALL register.
REQ-026 Clearing MASK[i] SHALL not clear PEND[i]; re-enabling MASK[i] SHALL re-assert irq one edge later if PEND[i] still set.
REQ-027 MODE change edge->level SHALL make PEND[i] follow s2[i] from the next edge; level->edge SHALL clear PEND[i], which then sets only on a later rising edge.
REQ-028 cs=0 writes SHALL have no effect; reads SHALL have no side effects.

Reset
REQ-029 On rst low, asynchronously: s1, s2, s3, PEND, MASK, MODE = 8'h00; dout = 8'h00; irq = 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending interrupts; after release no src edge SHALL register until s2/s3 observe a 0->1 transition after release.

Verification
REQ-031 Reset: rst low with src=8'hFF -> dout=8'h00, irq=0; after release, MASK=0 keeps irq=0 with PEND=8'hFF (level).
REQ-032 Edge latch and ack: MODE=8'h04, MASK=8'h04, pulse src[2] 3 cycles -> irq=1 at E3, VEC reads 8'h82; write VEC din=8'h02 -> PEND=0, irq=0 one edge later.
REQ-033 Priority: MODE=8'hFF, MASK=8'hFF, src 8'h00->8'h28 -> VEC=8'h83; ack 3 -> VEC=8'h85; ack 5 -> VEC=8'h00, irq=0.
REQ-034 Level mode: MODE=0, MASK=8'h01, src[0] high -> irq=1; W1C PEND din=8'h01 -> no change; src[0] low -> irq=0 within 3 edges.
REQ-035 Collision: edge on src[1] arriving in same cycle as W1C din=8'h02 -> PEND[1] stays 1.
REQ-036 Mask hold: pending edge bit 6, MASK 8'h00 -> irq=0, PEND=8'h40; write MASK=8'h40 -> irq=1 one edge later.

Source files
------------

// File: rtl/irq_ctl.sv
// Eight-source interrupt controller: synchronised sources, per-source edge/level
// pending latch, mask, fixed-priority vector and a small CPU register port.
module irq_ctl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] src,
    output logic       irq
);

    localparam logic [1:0] RS_PEND = 2'd0;
    localparam logic [1:0] RS_MASK = 2'd1;
    localparam logic [1:0] RS_MODE = 2'd2;
    localparam logic [1:0] RS_VEC  = 2'd3;

    logic [7:0] s1_q, s2_q, s3_q;
    logic [7:0] pend_q, pend_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] mode_q, mode_d;
    logic [7:0] dout_q, dout_d;
    logic       irq_q, irq_d;

    logic       wr_en;
    logic [7:0] clr;
    logic [7:0] set_edge;
    logic [7:0] act;
    logic [2:0] win;
    logic [7:0] vec;

    assign wr_en    = cs & we;
    assign set_edge = s2_q & ~s3_q;
    assign act      = pend_q & mask_q;
    assign vec      = {|act, 4'b0000, win};

    always_comb begin
        win = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) win = 3'(i);
        end
    end

    always_comb begin
        clr    = 8'h00;
        mask_d = mask_q;
        mode_d = mode_q;
        if (wr_en) begin
            case (rs)
                RS_PEND: clr = din;
                RS_MASK: mask_d = din;
                RS_MODE: mode_d = din;
                RS_VEC:  clr[din[2:0]] = 1'b1;
                default: ;
            endcase
        end
    end

    // Level bits mirror s2; switching a bit into edge mode drops it so that only a
    // fresh rising edge can latch it. Edge bits: set has priority over clear.
    always_comb begin
        pend_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (!mode_q[i]) begin
                pend_d[i] = mode_d[i] ? 1'b0 : s2_q[i];
            end else begin
                pend_d[i] = set_edge[i] | (pend_q[i] & ~clr[i]);
            end
        end
    end

    always_comb begin
        dout_d = 8'h00;
        case (rs)
            RS_PEND: dout_d = pend_q;
            RS_MASK: dout_d = mask_q;
            RS_MODE: dout_d = mode_q;
            RS_VEC:  dout_d = vec;
            default: dout_d = 8'h00;
        endcase
    end

    assign irq_d = |act;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 8'h00;
            s2_q   <= 8'h00;
            s3_q   <= 8'h00;
            pend_q <= 8'h00;
            mask_q <= 8'h00;
            mode_q <= 8'h00;
            dout_q <= 8'h00;
            irq_q  <= 1'b0;
        end else begin
            s1_q   <= src;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            dout_q <= dout_d;
            irq_q  <= irq_d;
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: drivers queue expected dout/irq values, a monitor
// compares them one clock later against the DUT outputs.
module tb_irq_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       we;
    logic [1:0] rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] src;
    logic       irq;

    // chk_kind: 0 none, 1 compare dout, 2 compare irq (one edge after request)
    logic [1:0] chk_kind = 2'd0;
    logic [1:0] kind_q   = 2'd0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    irq_ctl dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .rs   (rs),
        .din  (din),
        .dout (dout),
        .src  (src),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) kind_q <= chk_kind;

    always @(negedge clk) begin
        logic [7:0] act_v;
        logic [7:0] exp_v;
        string      nm;
        if (kind_q != 2'd0) begin
            checks++;
            act_v = (kind_q == 2'd1) ? dout : {7'b0, irq};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow got %02h", act_v);
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s got %02h expected %02h", nm, act_v, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        cs = 1'b0; we = 1'b0; chk_kind = 2'd0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_src(input logic [7:0] v);
        @(negedge clk);
        cs = 1'b0; we = 1'b0; chk_kind = 2'd0; src = v;
    endtask

    task automatic wr(input logic [1:0] r, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; rs = r; din = d; chk_kind = 2'd0;
    endtask

    task automatic wr_nocs(input logic [1:0] r, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b0; we = 1'b1; rs = r; din = d; chk_kind = 2'd0;
    endtask

    task automatic rd(input logic [1:0] r, input logic [7:0] e, input string nm);
        @(negedge clk);
        cs = 1'b0; we = 1'b0; rs = r; chk_kind = 2'd1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic ck_irq(input logic e, input string nm);
        @(negedge clk);
        cs = 1'b0; we = 1'b0; chk_kind = 2'd2;
        exp_q.push_back({7'b0, e});
        name_q.push_back(nm);
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; we = 1'b0; rs = 2'd0; din = 8'h00; src = 8'hFF;
        ticks(2);
        rd(2'd0, 8'h00, "rst_dout");
        ck_irq(1'b0, "rst_irq");
        @(negedge clk);
        rst = 1'b1; chk_kind = 2'd0;
        ticks(5);
        rd(2'd0, 8'hFF, "rst_pend_level");
        ck_irq(1'b0, "rst_irq_masked");
        rd(2'd1, 8'h00, "rst_mask");

        // edge latch and acknowledge on source 2
        set_src(8'h00);
        ticks(4);
        wr(2'd2, 8'h04);
        wr(2'd1, 8'h04);
        set_src(8'h04);
        ck_irq(1'b0, "edge_irq_e1");
        ck_irq(1'b0, "edge_irq_e2");
        ck_irq(1'b1, "edge_irq_e3");
        src = 8'h00;
        rd(2'd3, 8'h82, "edge_vec");
        wr(2'd3, 8'h02);
        ck_irq(1'b0, "ack_irq");
        rd(2'd0, 8'h00, "ack_pend");

        // priority between sources 3 and 5
        wr(2'd2, 8'hFF);
        wr(2'd1, 8'hFF);
        set_src(8'h28);
        ticks(4);
        rd(2'd3, 8'h83, "prio_vec3");
        wr(2'd3, 8'h03);
        rd(2'd3, 8'h85, "prio_vec5");
        wr(2'd3, 8'h05);
        rd(2'd3, 8'h00, "prio_vec_none");
        ck_irq(1'b0, "prio_irq_off");

        // level mode ignores write-1-to-clear
        wr(2'd2, 8'h00);
        wr(2'd1, 8'h01);
        set_src(8'h01);
        ticks(4);
        ck_irq(1'b1, "lvl_irq");
        wr(2'd0, 8'h01);
        ck_irq(1'b1, "lvl_w1c_irq");
        rd(2'd0, 8'h01, "lvl_w1c_pend");
        set_src(8'h00);
        tick();
        ck_irq(1'b1, "lvl_fall_e2");
        ck_irq(1'b0, "lvl_fall_e3");

        // set and clear on the same edge: set wins
        wr(2'd2, 8'h02);
        wr(2'd1, 8'h02);
        set_src(8'h02);
        tick();
        wr(2'd0, 8'h02);
        rd(2'd0, 8'h02, "collide_pend");
        wr(2'd0, 8'h02);
        rd(2'd0, 8'h00, "w1c_pend");

        // masking holds the pending bit
        set_src(8'h00);
        ticks(3);
        wr(2'd2, 8'h40);
        wr(2'd1, 8'h00);
        set_src(8'h40);
        ticks(3);
        ck_irq(1'b0, "mhold_irq");
        rd(2'd0, 8'h40, "mhold_pend");
        wr(2'd1, 8'h40);
        ck_irq(1'b1, "mhold_irq_on");
        rd(2'd2, 8'h40, "mode_rd");
        wr_nocs(2'd1, 8'hFF);
        rd(2'd1, 8'h40, "cs0_write");

        // level->edge switch drops the bit; held-high source does not re-latch
        wr(2'd2, 8'h00);
        wr(2'd2, 8'h40);
        tick();
        rd(2'd0, 8'h00, "l2e_clear");
        ck_irq(1'b0, "l2e_irq");

        // reset mid-operation
        wr(2'd2, 8'h00);
        ticks(2);
        ck_irq(1'b1, "pre_rst_irq");
        @(negedge clk);
        rst = 1'b0; chk_kind = 2'd0;
        rd(2'd1, 8'h00, "rst2_dout");
        ck_irq(1'b0, "rst2_irq");
        @(negedge clk);
        rst = 1'b1; chk_kind = 2'd0;
        rd(2'd1, 8'h00, "rst2_mask");
        ticks(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
